// File: rtl/rr_arbiter_4ch_pkg.sv
// Shared types and helpers for the 4-channel round-robin burst arbiter.
// Optional fixed-priority build: define RR_ARBITER_FIXED_PRIO_EN.
package rr_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh = 4'b0001 << sel;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter_4ch_if.sv
// Request/select/handshake bundle between requesters, arbiter and mux consumer.
// master = arbiter side, slave = requester/consumer side.
interface rr_arbiter_4ch_if;
    import rr_arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              out_ready;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] grant;
    logic              out_valid;
    logic              out_last;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output out_last
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  out_last
    );

endinterface

// File: rtl/rr_arbiter_4ch_pick.sv
// Combinational rotating-priority picker: first set req bit at ptr, ptr+1, ...
// Used by rr_arbiter_4ch (see RR_ARBITER_FIXED_PRIO_EN there).
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  winner,
    output logic              any
);

    logic [SEL_W-1:0] idx;

    // Scan farthest offset first so the closest requester overwrites last.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_arbiter_4ch.sv
// Round-robin 4-channel burst arbiter driving the mux select with valid/ready.
// Define RR_ARBITER_FIXED_PRIO_EN to pin the pointer at 0 (fixed priority).
module rr_arbiter_4ch
    import rr_arb_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arbiter_4ch_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_MAX - 1);
    localparam logic             LAST_INIT = (BURST_MAX == 1);

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [NUM_CH-1:0] grant_q;
    logic              valid_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              xfer;
    logic              rel;
    logic [SEL_W-1:0]  ptr_rel;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  winner;
    logic              any;

`ifdef RR_ARBITER_FIXED_PRIO_EN
    assign ptr_rel = '0;
`else
    assign ptr_rel = sel_q + SEL_W'(1);
`endif

    assign xfer = valid_q && bus.out_ready;

    // A dropped request releases even without a transfer (abort).
    assign rel = valid_q
              && (!bus.req[sel_q] || (bus.out_ready && cnt_q == CNT_LAST));

    assign pick_ptr = rel ? ptr_rel : ptr_q;

    rr_pick4 u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any) begin
                        state_q <= BUSY;
                        sel_q   <= winner;
                        grant_q <= onehot4(winner);
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        last_q  <= LAST_INIT;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        ptr_q <= ptr_rel;
                        if (any) begin
                            sel_q   <= winner;
                            grant_q <= onehot4(winner);
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            last_q  <= LAST_INIT;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            valid_q <= 1'b0;
                            cnt_q   <= '0;
                            last_q  <= 1'b0;
                        end
                    end else if (xfer) begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        last_q <= (cnt_q + CNT_W'(1)) == CNT_LAST;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;

endmodule
